btn_event_capture: RTL
======================

Name: btn_event_capture

Overview:
Input-side companion to the board LED driver. Samples raw push-button/switch lines, synchronises and debounces each one, and exposes the clean level vector. Each debounced press or release becomes an event code in a small first-word-fall-through FIFO, read through a valid/ready handshake. Sits between board pins and the control logic that drives the LEDs.

Parameters:
N_BTN, 16, number of input lines; IDXW = $clog2(N_BTN)
DEBOUNCE_CNT, 10, consecutive cycles a synchronised input must differ from the stable value before it is accepted (must be >= 2)
FIFO_DEPTH, 4, event FIFO entries (power of two)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
btn_in  input  N_BTN  raw asynchronous inputs, active-high
btn_state  output  N_BTN  debounced level per line
evt_valid  output  1  FIFO head holds an event
evt_ready  input  1  consumer accepts the head event this cycle
evt_code  output  IDXW+1  {kind, index}; kind 1 = press, 0 = release
evt_ovf  output  1  sticky flag: an event was lost
ovf_clr  input  1  single-cycle clear of evt_ovf

Behaviour:
- Reset, asynchronous: synchronisers, btn_state, debounce counters, pending flags and FIFO pointers all go to 0. evt_valid=0, evt_code=0, evt_ovf=0.
- Synchroniser: 2 flops per line. sync = second stage.
- Debounce, per line:
  - If sync == btn_state, counter resets to 0.
  - Otherwise the counter increments. At the edge where the counter equals DEBOUNCE_CNT-1:
    - btn_state bit takes the value of sync.
    - counter returns to 0.
    - pending[i] is set and pkind[i] = new level.
  - Counter width is $clog2(DEBOUNCE_CNT). It never wraps.
- Latency: a clean btn_in edge appears on btn_state DEBOUNCE_CNT+2 edges later. Any glitch shorter than DEBOUNCE_CNT synchronised cycles produces no change.
- Re-change while pending:
  - If a line's stable value changes again while pending[i] is still set, pkind[i] is overwritten with the newest level.
  - evt_ovf is set (the earlier event is lost).
  - Only one pending entry per line is kept.
- Scan/enqueue:
  - Each cycle, the lowest-index set pending bit is pushed as {pkind[i], i} and pending[i] is cleared.
  - Push is allowed when FIFO count < FIFO_DEPTH, or when the FIFO is full and a pop occurs in the same cycle.
  - Otherwise the pending bit stays set and nothing is lost.
  - At most one push per cycle.
- Simultaneous set and clear: if a line is being enqueued on the same edge it sets pending again, the new pending wins. The enqueued event is still written.
- FIFO:
  - First-word fall-through. evt_code is driven from the head entry. evt_valid = (count != 0).
  - Pop when evt_valid && evt_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - evt_code and evt_valid stay stable while evt_valid=1 and evt_ready=0.
- Empty-path latency: with an empty FIFO and no lower-index pending line, evt_valid rises 1 edge after the btn_state change.
- evt_ovf: set by the lost-event condition above. Cleared by ovf_clr unless a new loss occurs in the same cycle (set wins).
- Reset mid-operation: everything clears immediately. Queued and pending events are discarded. An input held high after reset re-debounces and produces a press event.

Optional Feature:
Macro BTN_EVT_TIMESTAMP_EN.
- Defined:
  - Adds a 16-bit free-running cycle counter (reset 0, wraps 0xFFFF->0).
  - Adds output evt_time[15:0], aligned with evt_code.
  - The counter value at the btn_state change edge is latched into ptime[i] and stored in the FIFO with the code. A re-change overwrites ptime[i].
- Undefined: no counter, no evt_time port, no extra storage.

Test Plan:
- Reset: assert rst with btn_in=16'hFFFF -> btn_state=0, evt_valid=0, evt_ovf=0. After release, each line debounces; 16 press events come out in index order: 0x10, 0x11, ... 0x1F.
- Clean press: btn_in[3] 0->1 and held, evt_ready=1 -> btn_state[3]=1 exactly 12 edges after the input edge; evt_valid pulses 1 cycle with evt_code=0x13. Release -> evt_code=0x03.
- Bounce: btn_in[5] high for 6 cycles, then low -> no btn_state change, no event. A 9-cycle pulse also gives no event; an 11-cycle pulse gives press then release events.
- Simultaneous: btn_in[0] and btn_in[9] rise on the same edge -> consecutive events 0x10 then 0x19.
- Backpressure/overflow: evt_ready=0, generate 4 events to fill the FIFO, then press and release line 7 -> evt_ovf=1, FIFO holds the first 4 unchanged. Raise evt_ready -> 4 events, then 0x07. Pulse ovf_clr -> evt_ovf=0.
- Timestamp (BTN_EVT_TIMESTAMP_EN): press line 2 after the 100th post-reset edge -> evt_time equals the counter at the btn_state change edge, with evt_code=0x12.

Source files
------------

// File: rtl/btn_event_capture.sv
// btn_event_capture: per-line 2-flop sync + debounce, press/release events in a FWFT FIFO.
// Optional macro BTN_EVT_TIMESTAMP_EN adds a 16-bit cycle stamp per event on evt_time.
module btn_event_capture #(
    parameter int N_BTN        = 16,
    parameter int DEBOUNCE_CNT = 10,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_BTN-1:0]       btn_in,
    output logic [N_BTN-1:0]       btn_state,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [$clog2(N_BTN):0] evt_code,
    output logic                   evt_ovf,
    input  logic                   ovf_clr
`ifdef BTN_EVT_TIMESTAMP_EN
    ,
    output logic [15:0]            evt_time
`endif
);
    localparam int IDXW = $clog2(N_BTN);
    localparam int EW   = IDXW + 1;
    localparam int CW   = $clog2(DEBOUNCE_CNT);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
    localparam logic [PW:0]   DEPTH_C  = (PW+1)'(FIFO_DEPTH);

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] state_q, state_d;
    logic [CW-1:0]    cnt_q [N_BTN];
    logic [CW-1:0]    cnt_d [N_BTN];
    logic [N_BTN-1:0] accept;
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] pkind_q, pkind_d;
    logic [N_BTN-1:0] clr;
    logic             ovf_q, ovf_d, loss;
    logic [IDXW-1:0]  push_idx;
    logic             found, push, pop;
    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      count_q, count_d;

    // Debounce: count cycles the synced input disagrees; accept on the last one.
    always_comb begin
        accept  = '0;
        state_d = state_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    state_d[i] = sync2_q[i];
                    accept[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Priority scan: lowest-index pending line is the push candidate.
    always_comb begin
        found    = 1'b0;
        push_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                found    = 1'b1;
                push_idx = IDXW'(i);
            end
        end
    end

    assign pop  = evt_valid & evt_ready;
    assign push = found & ((count_q != DEPTH_C) | pop);

    // Pending bookkeeping, loss detection and FIFO occupancy.
    always_comb begin
        clr = '0;
        if (push) clr[push_idx] = 1'b1;
        pend_d  = (pend_q & ~clr) | accept;
        pkind_d = (pkind_q & ~accept) | (state_d & accept);
        loss    = |(pend_q & ~clr & accept);
        ovf_d   = loss | (ovf_q & ~ovf_clr);
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Synchronisers, debounced state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= '0;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Pending flags, pending kinds and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            pkind_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            pkind_q <= pkind_d;
            ovf_q   <= ovf_d;
        end
    end

    // Event FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= {pkind_q[push_idx], push_idx};
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            count_q <= count_d;
        end
    end

`ifdef BTN_EVT_TIMESTAMP_EN
    logic [15:0] ts_q;
    logic [15:0] ptime_q [N_BTN];
    logic [15:0] tmem_q  [FIFO_DEPTH];

    // Free-running stamp, per-line capture and FIFO side storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q <= '0;
            for (int i = 0; i < N_BTN; i++) ptime_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) tmem_q[i] <= '0;
        end else begin
            ts_q <= ts_q + 16'd1;
            for (int i = 0; i < N_BTN; i++) begin
                if (accept[i]) ptime_q[i] <= ts_q;
            end
            if (push) tmem_q[wr_q] <= ptime_q[push_idx];
        end
    end

    assign evt_time = tmem_q[rd_q];
`endif

    assign btn_state = state_q;
    assign evt_valid = (count_q != '0);
    assign evt_code  = mem_q[rd_q];
    assign evt_ovf   = ovf_q;

endmodule
